ehl_ahb_decoder_mux: RTL and testbench

AHB-Lite address decoder and slave response multiplexer. It sits between a single master and up to NSLV slaves plus ehl_ahb_default_slave, and drives that slave's hsel and hready_in. It decodes the address phase, registers the selected slave for the data phase, and returns that slave's hready/hresp/hrdata to the master. It also records accesses to unmapped addresses for debug.

---
 rtl/ehl_ahb_decoder_mux.sv | 121 ++++++++++++
 tb/tb_ehl_ahb_decoder_mux.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ehl_ahb_decoder_mux.sv
// rtl/ehl_ahb_decoder_mux.sv - AHB-Lite address decoder and slave response multiplexer
`timescale 1ns/1ps
module ehl_ahb_decoder_mux #(
  parameter int                    NSLV = 4,
  parameter logic [32*NSLV-1:0]    BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NSLV-1:0]    MASK = {NSLV{32'hF000_0000}}
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [31:0]          haddr,
  input  logic [1:0]           htrans,
  output logic                 hready,
  output logic [1:0]           hresp,
  output logic [31:0]          hrdata,
  output logic [NSLV-1:0]      hsel_s,
  output logic                 hsel_def,
  input  logic [NSLV-1:0]      hready_s,
  input  logic [2*NSLV-1:0]    hresp_s,
  input  logic [32*NSLV-1:0]   hrdata_s,
  input  logic                 hready_d,
  input  logic [1:0]           hresp_d,
  input  logic [31:0]          hrdata_d,
  input  logic                 err_clr,
  output logic [31:0]          err_addr,
  output logic [7:0]           err_cnt
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  // Data-phase target: no transfer, one of the mapped slaves, or the default slave.
  typedef enum logic [1:0] {D_NONE, D_SLV, D_DEF} dkind_t;

  dkind_t          dkind;
  logic [IW-1:0]   didx;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic            capture;
  logic            unused_htrans;

  // Only htrans[1] distinguishes active transfers from IDLE/BUSY here.
  assign unused_htrans = htrans[0];

  // Address decode; scanning from the top down lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hsel_s  = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((haddr & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
        hit       = 1'b1;
        hit_idx   = IW'(i);
        hsel_s    = '0;
        hsel_s[i] = 1'b1;
      end
    end
    hsel_def = ~hit;
  end

  // Register the decoded target for the data phase; wait states hold it.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dkind <= D_NONE;
      didx  <= '0;
    end else if (hready) begin
      if (!htrans[1]) begin
        dkind <= D_NONE;
        didx  <= '0;
      end else if (hit) begin
        dkind <= D_SLV;
        didx  <= hit_idx;
      end else begin
        dkind <= D_DEF;
        didx  <= '0;
      end
    end
  end

  // Response mux from the registered target; zero added latency from slave to master.
  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = 32'h0;
    case (dkind)
      D_SLV: begin
        hready = hready_s[didx];
        hresp  = hresp_s[2*int'(didx) +: 2];
        hrdata = hrdata_s[32*int'(didx) +: 32];
      end
      D_DEF: begin
        hready = hready_d;
        hresp  = hresp_d;
        hrdata = hrdata_d;
      end
      default: begin
        hready = 1'b1;
        hresp  = 2'b00;
        hrdata = 32'h0;
      end
    endcase
  end

  assign capture = hready & hsel_def & htrans[1];

  // Record unmapped accesses; a clear coinciding with a capture counts that capture.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_addr <= 32'h0;
      err_cnt  <= 8'h00;
    end else if (capture) begin
      err_addr <= haddr;
      if (err_clr) begin
        err_cnt <= 8'h01;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'h01;
      end
    end else if (err_clr) begin
      err_cnt <= 8'h00;
    end
  end

endmodule

// File: tb/tb_ehl_ahb_decoder_mux.sv
// tb/tb_ehl_ahb_decoder_mux.sv - directed scoreboard bench for ehl_ahb_decoder_mux
`timescale 1ns/1ps
module tb_ehl_ahb_decoder_mux;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hready;
  logic [1:0]    hresp;
  logic [31:0]   hrdata;
  logic [3:0]    hsel_s;
  logic          hsel_def;
  logic [3:0]    hready_s;
  logic [7:0]    hresp_s;
  logic [127:0]  hrdata_s;
  logic          hready_d;
  logic [1:0]    hresp_d;
  logic [31:0]   hrdata_d;
  logic          err_clr;
  logic [31:0]   err_addr;
  logic [7:0]    err_cnt;

  // overlapping-map instance outputs
  logic          o_hready;
  logic [1:0]    o_hresp;
  logic [31:0]   o_hrdata;
  logic [3:0]    o_hsel_s;
  logic          o_hsel_def;
  logic [31:0]   o_err_addr;
  logic [7:0]    o_err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  always #5 hclk = ~hclk;

  ehl_ahb_decoder_mux u_dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .hsel_s(hsel_s), .hsel_def(hsel_def),
    .hready_s(hready_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
    .hready_d(hready_d), .hresp_d(hresp_d), .hrdata_d(hrdata_d),
    .err_clr(err_clr), .err_addr(err_addr), .err_cnt(err_cnt)
  );

  ehl_ahb_decoder_mux #(
    .NSLV(4),
    .BASE({32'h3000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000}),
    .MASK({32'hF000_0000, 32'h0000_0000, 32'h0000_0000, 32'hF000_0000})
  ) u_ovl (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hready(o_hready), .hresp(o_hresp), .hrdata(o_hrdata),
    .hsel_s(o_hsel_s), .hsel_def(o_hsel_def),
    .hready_s(hready_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
    .hready_d(hready_d), .hresp_d(hresp_d), .hrdata_d(hrdata_d),
    .err_clr(err_clr), .err_addr(o_err_addr), .err_cnt(o_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.data = d;
    e.resp = r;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_hready"}, 32'(hready), 32'd1);
      chk({tag, "_hrdata"}, hrdata, e.data);
      chk({tag, "_hresp"}, 32'(hresp), 32'(e.resp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hresetn  = 1'b0;
    haddr    = 32'h0;
    htrans   = 2'b00;
    err_clr  = 1'b0;
    hready_s = 4'hF;
    hresp_s  = 8'h00;
    hrdata_s = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    hready_d = 1'b1;
    hresp_d  = 2'b00;
    hrdata_d = 32'hDEF0_0000;

    // reset state
    #3;
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    hresetn = 1'b1;

    // wait-state read from slave 1
    haddr = 32'h1000_0004; htrans = 2'b10;
    #1;
    chk("t1_hsel_s", 32'(hsel_s), 32'h2);
    chk("t1_hsel_def", 32'(hsel_def), 32'd0);
    chk("t1_addr_hready", 32'(hready), 32'd1);
    push(32'hCAFE_0001, 2'b00);
    tick();
    htrans = 2'b00; haddr = 32'h0; hready_s[1] = 1'b0;
    #1;
    chk("t1_wait1", 32'(hready), 32'd0);
    tick();
    chk("t1_wait2", 32'(hready), 32'd0);
    tick();
    hready_s[1] = 1'b1; hrdata_s[63:32] = 32'hCAFE_0001;
    #1;
    pop_chk("t1_done");
    tick();
    chk("t1_idle_hrdata", hrdata, 32'h0);

    // unmapped access with two-cycle ERROR from the default slave
    haddr = 32'h5000_0000; htrans = 2'b10;
    #1;
    chk("t2_hsel_def", 32'(hsel_def), 32'd1);
    chk("t2_hsel_s", 32'(hsel_s), 32'h0);
    push(32'hDEF0_0000, 2'b01);
    tick();
    chk("t2_err_addr", err_addr, 32'h5000_0000);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    hready_d = 1'b0; hresp_d = 2'b01; haddr = 32'h6000_0000; htrans = 2'b10;
    #1;
    chk("t2_err1_hready", 32'(hready), 32'd0);
    chk("t2_err1_hresp", 32'(hresp), 32'd1);
    tick();
    htrans = 2'b00; hready_d = 1'b1;
    #1;
    pop_chk("t2_err2");
    chk("t2_no_capture_cnt", 32'(err_cnt), 32'd1);
    chk("t2_no_capture_addr", err_addr, 32'h5000_0000);
    tick();
    hresp_d = 2'b00;
    #1;
    chk("t2_after_hresp", 32'(hresp), 32'd0);
    chk("t2_after_hready", 32'(hready), 32'd1);

    // pipelined accesses slave 0 then slave 3
    haddr = 32'h0000_0010; htrans = 2'b10;
    #1;
    chk("t3_hsel_s0", 32'(hsel_s), 32'h1);
    push(32'hA000_0000, 2'b00);
    tick();
    haddr = 32'h3000_0000; htrans = 2'b10;
    #1;
    chk("t3_hsel_s3", 32'(hsel_s), 32'h8);
    pop_chk("t3_s0");
    push(32'hA000_0003, 2'b00);
    tick();
    htrans = 2'b00;
    #1;
    pop_chk("t3_s3");
    tick();
    chk("t3_idle_hrdata", hrdata, 32'h0);

    // overlapping map priority
    haddr = 32'h2000_0000;
    #1;
    chk("t4_ovl_hsel_s", 32'(o_hsel_s), 32'h2);
    chk("t4_ovl_hsel_def", 32'(o_hsel_def), 32'd0);
    chk("t4_main_hsel_s", 32'(hsel_s), 32'h4);
    haddr = 32'h0000_0000;
    #1;
    chk("t4_ovl_low", 32'(o_hsel_s), 32'h1);

    // error counter edges
    err_clr = 1'b1; htrans = 2'b00;
    tick();
    err_clr = 1'b0;
    chk("t5_clr", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 257; i++) begin
      haddr = 32'h8000_0000 | (32'(i) << 2); htrans = 2'b10;
      tick();
      if (i == 253) chk("t5_cnt_254", 32'(err_cnt), 32'hFE);
      if (i == 255) chk("t5_cnt_256", 32'(err_cnt), 32'hFF);
      if (i == 256) begin
        chk("t5_cnt_257", 32'(err_cnt), 32'hFF);
        chk("t5_addr_257", err_addr, 32'h8000_0400);
      end
    end
    err_clr = 1'b1; haddr = 32'h9000_0000; htrans = 2'b10;
    tick();
    err_clr = 1'b0;
    chk("t5_clr_capture_cnt", 32'(err_cnt), 32'd1);
    chk("t5_clr_capture_addr", err_addr, 32'h9000_0000);
    haddr = 32'hA000_0000; htrans = 2'b00;
    tick();
    chk("t5_idle_cnt", 32'(err_cnt), 32'd1);
    chk("t5_idle_addr", err_addr, 32'h9000_0000);
    tick();

    // reset while slave 2 is stalling
    haddr = 32'h2000_0000; htrans = 2'b10;
    #1;
    chk("t6_hsel_s", 32'(hsel_s), 32'h4);
    tick();
    htrans = 2'b00; haddr = 32'h0; hready_s[2] = 1'b0; hresp_s[5:4] = 2'b01;
    #1;
    chk("t6_stall", 32'(hready), 32'd0);
    #2;
    hresetn = 1'b0;
    #1;
    chk("t6_rst_hready", 32'(hready), 32'd1);
    chk("t6_rst_hresp", 32'(hresp), 32'd0);
    chk("t6_rst_hrdata", hrdata, 32'h0);
    chk("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("t6_rst_err_addr", err_addr, 32'h0);
    hready_s[2] = 1'b1; hresp_s[5:4] = 2'b00;
    tick();
    hresetn = 1'b1;
    #1;
    chk("t6_post_hready", 32'(hready), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
